// File: rtl/multi_wave_gen.sv
// multi_wave_gen: N-channel square-wave generator with per-channel runtime
// half-period, enable and toggle strobe. Channels are fully independent.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   locked    clock-wizard lock; low freezes counters and outputs
//   ch_en     per-channel run enable
//   sync      one-cycle pulse, phase-aligns every channel
//   wr_en     config write strobe
//   wr_ch     target channel of the write (>= NUM_CH is ignored)
//   wr_data   value written to the shadow register
//   wr_reg    (WAVE_DUTY_CTRL_EN only) 0 = period register, 1 = duty register
//   wave_out  registered square-wave outputs
//   tc        one-cycle strobe, high when wave_out first shows a new level
//
// Optional feature: define WAVE_DUTY_CTRL_EN for period/duty PWM mode.
// Without it every channel is a 50% toggle with half-period N+1 clocks.
module multi_wave_gen #(
    parameter int                NUM_CH       = 3,
    parameter int                CNT_W        = 24,
    parameter logic [CNT_W-1:0]  DEFAULT_HALF = 24'h24C5D9,
    parameter logic              IDLE_LEVEL   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
`ifdef WAVE_DUTY_CTRL_EN
    input  logic              wr_reg,
`endif
    output logic [NUM_CH-1:0] wave_out,
    output logic [NUM_CH-1:0] tc
);

`ifdef WAVE_DUTY_CTRL_EN
    // Reset period 2*(N+1) clocks with 50% duty, matching the toggle mode.
    localparam logic [CNT_W-1:0] P_DEF = {DEFAULT_HALF[CNT_W-2:0], 1'b1};
    localparam logic [CNT_W-1:0] D_DEF = DEFAULT_HALF + CNT_W'(1);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             hit;
        logic [CNT_W-1:0] cnt;
        logic             wave_q;
        logic             tc_q;

        // wr_ch is 4 bits and i < NUM_CH, so out-of-range indices match no channel.
        assign hit         = wr_en && (wr_ch == 4'(i));
        assign wave_out[i] = wave_q;
        assign tc[i]       = tc_q;

`ifdef WAVE_DUTY_CTRL_EN
        logic [CNT_W-1:0] p_shd, p_act;
        logic [CNT_W-1:0] d_shd, d_act;
        logic             below;

        // Level for the next count value (cnt+1) against the active duty.
        assign below = ({1'b0, cnt} + 1'b1) < {1'b0, d_act};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_shd <= P_DEF;
                d_shd <= D_DEF;
            end else if (hit) begin
                if (wr_reg) d_shd <= wr_data;
                else        p_shd <= wr_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                p_act  <= P_DEF;
                d_act  <= D_DEF;
                wave_q <= IDLE_LEVEL;
                tc_q   <= 1'b0;
            end else if (!locked) begin
                tc_q <= 1'b0;
            end else if (sync || !ch_en[i]) begin
                cnt    <= '0;
                p_act  <= p_shd;
                d_act  <= d_shd;
                wave_q <= IDLE_LEVEL;
                tc_q   <= 1'b0;
            end else if (cnt == p_act) begin
                // Wrap: new period/duty take effect for the whole next cycle.
                cnt    <= '0;
                p_act  <= p_shd;
                d_act  <= d_shd;
                wave_q <= (d_shd != '0) ? ~IDLE_LEVEL : IDLE_LEVEL;
                tc_q   <= 1'b1;
            end else begin
                cnt    <= cnt + 1'b1;
                wave_q <= below ? ~IDLE_LEVEL : IDLE_LEVEL;
                tc_q   <= 1'b0;
            end
        end
`else
        logic [CNT_W-1:0] shd;
        logic [CNT_W-1:0] act;

        // Shadow keeps accepting writes even while locked is low.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)      shd <= DEFAULT_HALF;
            else if (hit) shd <= wr_data;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                act    <= DEFAULT_HALF;
                wave_q <= IDLE_LEVEL;
                tc_q   <= 1'b0;
            end else if (!locked) begin
                tc_q <= 1'b0;
            end else if (sync || !ch_en[i]) begin
                cnt    <= '0;
                act    <= shd;
                wave_q <= IDLE_LEVEL;
                tc_q   <= 1'b0;
            end else if (cnt == act) begin
                // Active value only changes here, so cnt never exceeds act.
                cnt    <= '0;
                act    <= shd;
                wave_q <= ~wave_q;
                tc_q   <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tc_q <= 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_multi_wave_gen.sv
// tb_multi_wave_gen: directed + randomized bench for multi_wave_gen.
// Reference model schedules each channel's next toggle as an absolute edge.
module tb_multi_wave_gen;
    localparam int               NUM_CH = 3;
    localparam int               CNT_W  = 24;
    localparam logic             IDLE   = 1'b1;
    localparam logic [CNT_W-1:0] DEF    = 24'h24C5D9;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              locked = 1'b1;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync = 1'b0;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_ch = '0;
    logic [CNT_W-1:0]  wr_data = '0;
    logic              wr_reg = 1'b0;
    logic [NUM_CH-1:0] wave_out;
    logic [NUM_CH-1:0] tc;

    int errors = 0;
    int checks = 0;
    int t = 0;
    int tc0_seen;

    // Model state: level, pending tc, shadow value, edge of next toggle.
    logic m_lvl[NUM_CH];
    logic m_tc[NUM_CH];
    int   m_s[NUM_CH];
    int   m_due[NUM_CH];

    always #5 clk = ~clk;

    multi_wave_gen #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEFAULT_HALF(DEF),
        .IDLE_LEVEL(IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .locked(locked),
        .ch_en(ch_en),
        .sync(sync),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_data(wr_data),
`ifdef WAVE_DUTY_CTRL_EN
        .wr_reg(wr_reg),
`endif
        .wave_out(wave_out),
        .tc(tc)
    );

    task automatic model_edge();
        int s_old;
        for (int i = 0; i < NUM_CH; i++) begin
            s_old = m_s[i];
            if (rst) begin
                m_lvl[i] = IDLE;
                m_tc[i]  = 1'b0;
                m_s[i]   = int'(DEF);
                m_due[i] = t + int'(DEF) + 1;
            end else begin
                if (wr_en && int'(wr_ch) == i) m_s[i] = int'(wr_data);
                if (!locked) begin
                    m_due[i] = m_due[i] + 1;
                    m_tc[i]  = 1'b0;
                end else if (sync || !ch_en[i]) begin
                    m_lvl[i] = IDLE;
                    m_tc[i]  = 1'b0;
                    m_due[i] = t + s_old + 1;
                end else if (t == m_due[i]) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_tc[i]  = 1'b1;
                    m_due[i] = t + s_old + 1;
                end else begin
                    m_tc[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] ew;
        logic [NUM_CH-1:0] et;
        for (int i = 0; i < NUM_CH; i++) begin
            ew[i] = m_lvl[i];
            et[i] = m_tc[i];
        end
        checks++;
        assert (wave_out === ew) else begin
            errors++;
            $error("FAIL wave edge=%0d got=%b want=%b", t, wave_out, ew);
        end
        checks++;
        assert (tc === et) else begin
            errors++;
            $error("FAIL tc edge=%0d got=%b want=%b", t, tc, et);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
            t++;
        end
    endtask

    task automatic write(input int ch, input int val);
        wr_en   = 1'b1;
        wr_ch   = 4'(ch);
        wr_data = CNT_W'(val);
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_lvl[i] = IDLE;
            m_tc[i]  = 1'b0;
            m_s[i]   = int'(DEF);
            m_due[i] = int'(DEF) + 1;
        end

        // Asynchronous reset, observed before any clock edge.
        #2 rst = 1'b1;
        #1;
        checks++;
        assert (wave_out === 3'b111 && tc === 3'b000) else begin
            errors++;
            $error("FAIL reset_async got=%b/%b want=111/000", wave_out, tc);
        end
        step(2);
        rst = 1'b0;
        step(1);

        // Reset and enable: ch0 N=3 gives toggles every 4 edges.
        write(0, 3);
        step(1);
        ch_en = 3'b001;
        tc0_seen = 0;
        for (int k = 0; k < 13; k++) begin
            step(1);
            if (tc[0]) tc0_seen++;
        end
        checks++;
        assert (tc0_seen === 3 && wave_out[2:1] === 2'b11) else begin
            errors++;
            $error("FAIL enable_toggles got=%0d/%b want=3/11", tc0_seen, wave_out[2:1]);
        end

        // Independence: N = 2, 3, 4 with simultaneous terminal counts.
        ch_en = 3'b000;
        write(0, 2);
        write(1, 3);
        write(2, 4);
        step(1);
        ch_en = 3'b111;
        step(64);

        // Shadow apply: shrink from 9 to 1 mid half-period.
        write(0, 9);
        ch_en = 3'b110;
        step(1);
        ch_en = 3'b111;
        step(6);
        write(0, 1);
        step(30);

        // locked low for 7 cycles mid-count; shadow write still accepted.
        step(3);
        locked = 1'b0;
        step(3);
        write(2, 6);
        step(3);
        locked = 1'b1;
        step(25);

        // sync: every channel idle on the next edge.
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++;
        assert (wave_out === 3'b111 && tc === 3'b000) else begin
            errors++;
            $error("FAIL sync got=%b/%b want=111/000", wave_out, tc);
        end
        step(20);

        // Out-of-range channel write must not touch any channel.
        write(5, 0);
        write(3, 0);
        write(15, 0);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        step(30);

        // Disable ch1 mid-period, then restart it; ch2 at N=0.
        ch_en = 3'b101;
        step(3);
        write(2, 0);
        ch_en = 3'b111;
        step(20);

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NUM_CH; i++)
                ch_en[i] = ($urandom_range(0, 9) != 0);
            locked  = ($urandom_range(0, 9) != 0);
            sync    = ($urandom_range(0, 39) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 4'($urandom_range(0, 4));
            wr_data = CNT_W'($urandom_range(0, 6));
            step(1);
        end
        wr_en  = 1'b0;
        sync   = 1'b0;
        locked = 1'b1;
        ch_en  = 3'b111;
        step(20);

        // Reset mid-operation returns outputs to idle without a clock.
        #3 rst = 1'b1;
        #1;
        checks++;
        assert (wave_out === 3'b111 && tc === 3'b000) else begin
            errors++;
            $error("FAIL reset_mid got=%b/%b want=111/000", wave_out, tc);
        end
        step(1);
        rst = 1'b0;
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
